// File: rtl/frame_pkg.sv
// Shared frame-buffer constants and the rectangle-fill state type.
// Used by the rectangle filler, the frame buffer and the VGA read side.
package frame_pkg;

   localparam int H_RES     = 640;
   localparam int V_RES     = 480;
   localparam int FB_DEPTH  = H_RES * V_RES;   // 307200
   localparam int FB_ADDR_W = 20;
   localparam int PIX_W     = 4;

   typedef enum logic [1:0] {
      IDLE,
      SETUP,
      FILL,
      DONE
   } fill_state_t;

endpackage

// File: rtl/frame_rect_filler_if.sv
// Command handshake and frame-buffer write bus of the rectangle filler.
//   cmd_valid/cmd_ready  : command handshake
//   cmd_x/y/w/h/color    : rectangle origin, size and palette index
//   WE/drawPtFrame/drawData : one frame-buffer write per clock
// master = command source / write sink, slave = the filler.
interface frame_rect_filler_if;
   import frame_pkg::*;

   logic                 cmd_valid;
   logic                 cmd_ready;
   logic [9:0]           cmd_x;
   logic [8:0]           cmd_y;
   logic [9:0]           cmd_w;
   logic [8:0]           cmd_h;
   logic [PIX_W-1:0]     cmd_color;
   logic                 WE;
   logic [FB_ADDR_W-1:0] drawPtFrame;
   logic [PIX_W-1:0]     drawData;

   modport master (
      output cmd_valid, cmd_x, cmd_y, cmd_w, cmd_h, cmd_color,
      input  cmd_ready, WE, drawPtFrame, drawData
   );

   modport slave (
      input  cmd_valid, cmd_x, cmd_y, cmd_w, cmd_h, cmd_color,
      output cmd_ready, WE, drawPtFrame, drawData
   );

endinterface

// File: rtl/frame_rect_clip.sv
// Combinational clipping of a rectangle against the visible screen.
//   x, y, w, h : rectangle origin and size
//   x_end      : exclusive right edge, min(x+w, H_RES)
//   y_end      : exclusive bottom edge, min(y+h, V_RES)
//   empty      : nothing of the rectangle is on screen
module frame_rect_clip
   import frame_pkg::*;
(
   input  logic [9:0]  x,
   input  logic [8:0]  y,
   input  logic [9:0]  w,
   input  logic [8:0]  h,
   output logic [10:0] x_end,
   output logic [9:0]  y_end,
   output logic        empty
);

   logic [10:0] x_sum;
   logic [9:0]  y_sum;

   // One extra bit on each sum so x+w and y+h cannot wrap.
   assign x_sum = {1'b0, x} + {1'b0, w};
   assign y_sum = {1'b0, y} + {1'b0, h};

   assign x_end = (x_sum > 11'(H_RES)) ? 11'(H_RES) : x_sum;
   assign y_end = (y_sum > 10'(V_RES)) ? 10'(V_RES) : y_sum;

   assign empty = (w == '0) || (h == '0) ||
                  (x >= 10'(H_RES)) || (y >= 9'(V_RES));

endmodule

// File: rtl/frame_rect_filler.sv
// Rectangle-fill drawing engine for the 640x480 4bpp frame buffer.
// Accepts one command, clips it to the screen and emits one write per clock.
//   Clk, Reset_h : clock, synchronous active-high reset
//   bus          : command handshake in, frame-buffer writes out
//   busy         : command in progress
//   done         : one-cycle pulse after the last write of a command
//
// state | meaning
// IDLE  | waiting for a command, cmd_ready high
// SETUP | clip and compute the first row base
// FILL  | one pixel write per cycle, row-major
// DONE  | writes finished, done pulse registered on exit
module frame_rect_filler
   import frame_pkg::*;
(
   input  logic                 Clk,
   input  logic                 Reset_h,
   frame_rect_filler_if.slave   bus,
   output logic                 busy,
   output logic                 done
);

   fill_state_t state, state_nxt;

   logic [9:0]           x_q;
   logic [8:0]           y_q;
   logic [9:0]           w_q;
   logic [8:0]           h_q;
   logic [PIX_W-1:0]     color_q;
   logic [9:0]           col;
   logic [8:0]           row;
   logic [FB_ADDR_W-1:0] row_base;
   logic [10:0]          x_end;
   logic [9:0]           y_end;
   logic                 empty;
   logic                 col_last;
   logic                 row_last;

   // Fed from the latched fields, so the bounds are stable through FILL.
   frame_rect_clip u_clip (
      .x     (x_q),
      .y     (y_q),
      .w     (w_q),
      .h     (h_q),
      .x_end (x_end),
      .y_end (y_end),
      .empty (empty)
   );

   assign bus.cmd_ready = (state == IDLE);
   assign busy          = (state != IDLE);
   assign col_last      = ({1'b0, col} == (x_end - 11'd1));
   assign row_last      = ({1'b0, row} == (y_end - 10'd1));

   always_ff @(posedge Clk) begin
      if (Reset_h) state <= IDLE;
      else         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (bus.cmd_valid)        state_nxt = SETUP;
         SETUP:   state_nxt = empty ? DONE : FILL;
         FILL:    if (col_last && row_last) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Reset_h) begin
         bus.WE          <= 1'b0;
         bus.drawPtFrame <= '0;
         bus.drawData    <= '0;
         done            <= 1'b0;
         x_q             <= '0;
         y_q             <= '0;
         w_q             <= '0;
         h_q             <= '0;
         color_q         <= '0;
         col             <= '0;
         row             <= '0;
         row_base        <= '0;
      end else begin
         bus.WE <= 1'b0;
         done   <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.cmd_valid) begin
                  x_q     <= bus.cmd_x;
                  y_q     <= bus.cmd_y;
                  w_q     <= bus.cmd_w;
                  h_q     <= bus.cmd_h;
                  color_q <= bus.cmd_color;
               end
            end
            SETUP: begin
               col      <= x_q;
               row      <= y_q;
               // y*640 = y*512 + y*128
               row_base <= ({11'd0, y_q} << 9) + ({11'd0, y_q} << 7);
            end
            FILL: begin
               bus.WE          <= 1'b1;
               bus.drawPtFrame <= row_base + {10'd0, col};
               bus.drawData    <= color_q;
               if (col_last) begin
                  col      <= x_q;
                  row      <= row + 9'd1;
                  row_base <= row_base + FB_ADDR_W'(H_RES);
               end else begin
                  col <= col + 10'd1;
               end
            end
            DONE: done <= 1'b1;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_frame_rect_filler.sv
module tb_frame_rect_filler;
   import frame_pkg::*;

   logic Clk = 1'b0;
   logic Reset_h;
   logic busy;
   logic done;

   always #5 Clk = ~Clk;

   frame_rect_filler_if bus ();

   frame_rect_filler dut (
      .Clk     (Clk),
      .Reset_h (Reset_h),
      .bus     (bus),
      .busy    (busy),
      .done    (done)
   );

   int n_pass  = 0;
   int n_total = 0;
   int n_fail  = 0;
   int exp_q[$];
   int obs_q[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_total++;
      assert (obs === expv) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
      end
   endtask

   // Reference: every on-screen pixel of the rectangle, row-major.
   task automatic model(input int x, input int y, input int w, input int h);
      int xe, ye;
      exp_q.delete();
      xe = (x + w > H_RES) ? H_RES : x + w;
      ye = (y + h > V_RES) ? V_RES : y + h;
      for (int r = y; r < ye; r++)
         for (int c = x; c < xe; c++)
            exp_q.push_back(r * H_RES + c);
   endtask

   task automatic drive_fields(input int x, input int y, input int w, input int h, input int c);
      bus.cmd_x     = 10'(x);
      bus.cmd_y     = 9'(y);
      bus.cmd_w     = 10'(w);
      bus.cmd_h     = 9'(h);
      bus.cmd_color = PIX_W'(c);
   endtask

   // Ends #1 after the accepting edge.
   task automatic start_cmd(input int x, input int y, input int w, input int h,
                            input int c, input bit keep);
      int t;
      @(negedge Clk);
      drive_fields(x, y, w, h, c);
      bus.cmd_valid = 1'b1;
      t = 0;
      while (!bus.cmd_ready && t < 50) begin
         @(negedge Clk);
         t++;
      end
      chk("accept_wait", 32'(t < 50), 32'd1);
      @(posedge Clk);
      #1;
      chk("ready_low_after_accept", 32'(bus.cmd_ready), 32'd0);
      chk("busy_after_accept", 32'(busy), 32'd1);
      if (!keep) bus.cmd_valid = 1'b0;
   endtask

   // Starts #1 after the accepting edge, ends #1 after the edge raising done.
   task automatic collect(input int x, input int y, input int w, input int h,
                          input int c, input bit scramble, input string tag);
      int n, nw, first, donek, bad_idx, bad_gap, bad_data;
      model(x, y, w, h);
      n = exp_q.size();
      obs_q.delete();
      nw = 0; first = -1; donek = -1; bad_idx = 0; bad_gap = 0; bad_data = 0;
      for (int k = 1; k <= n + 10; k++) begin
         @(posedge Clk);
         #1;
         if (scramble)
            drive_fields($urandom_range(0, 1023), $urandom_range(0, 511),
                         $urandom_range(0, 1023), $urandom_range(0, 511),
                         $urandom_range(0, 15));
         if (bus.WE) begin
            if (first < 0) first = k;
            obs_q.push_back(int'(bus.drawPtFrame));
            if (nw >= n || int'(bus.drawPtFrame) != exp_q[nw]) bad_idx++;
            if (k != first + nw) bad_gap++;
            if (int'(bus.drawData) != c) bad_data++;
            nw++;
         end
         if (done) begin
            donek = k;
            break;
         end
      end
      chk({tag, "_write_count"}, 32'(nw), 32'(n));
      if (n > 0) chk({tag, "_first_write_cycle"}, 32'(first), 32'd2);
      chk({tag, "_bad_index"}, 32'(bad_idx), 32'd0);
      chk({tag, "_gaps"}, 32'(bad_gap), 32'd0);
      chk({tag, "_bad_data"}, 32'(bad_data), 32'd0);
      chk({tag, "_done_cycle"}, 32'(donek), 32'(n + 2));
      chk({tag, "_we_low_at_done"}, 32'(bus.WE), 32'd0);
   endtask

   task automatic run_cmd(input int x, input int y, input int w, input int h,
                          input int c, input string tag);
      start_cmd(x, y, w, h, c, 1'b0);
      collect(x, y, w, h, c, 1'b0, tag);
      @(posedge Clk);
      #1;
      chk({tag, "_done_single"}, 32'(done), 32'd0);
      chk({tag, "_ready_after_done"}, 32'(bus.cmd_ready), 32'd1);
   endtask

   initial begin
      int lit[6];
      int wcnt;
      Reset_h       = 1'b1;
      bus.cmd_valid = 1'b0;
      drive_fields(0, 0, 0, 0, 0);
      repeat (3) @(posedge Clk);
      #1;
      chk("rst_we", 32'(bus.WE), 32'd0);
      chk("rst_pt", 32'(bus.drawPtFrame), 32'd0);
      chk("rst_data", 32'(bus.drawData), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_ready", 32'(bus.cmd_ready), 32'd1);
      Reset_h = 1'b0;

      // Small directed rectangle with literal expected addresses.
      run_cmd(2, 1, 3, 2, 'hA, "basic");
      lit = '{642, 643, 644, 1282, 1283, 1284};
      for (int i = 0; i < 6; i++)
         chk($sformatf("basic_lit_%0d", i), 32'(i < obs_q.size() ? obs_q[i] : -1), 32'(lit[i]));

      run_cmd(10, 10, 0, 5, 3, "empty_w0");
      run_cmd(700, 10, 5, 5, 3, "empty_x700");

      run_cmd(638, 479, 10, 10, 5, "clip");
      chk("clip_lit_0", 32'(obs_q.size() > 0 ? obs_q[0] : -1), 32'd307198);
      chk("clip_lit_1", 32'(obs_q.size() > 1 ? obs_q[1] : -1), 32'd307199);

      // Full-width band to the bottom of the screen: last index must be 307199.
      run_cmd(0, 440, 640, 40, 0, "band");
      chk("band_last", 32'(obs_q.size() > 0 ? obs_q[obs_q.size()-1] : -1), 32'd307199);

      // Held cmd_valid with changing fields: first command unaffected,
      // the next is accepted in the IDLE cycle after done.
      start_cmd(20, 30, 5, 3, 7, 1'b1);
      collect(20, 30, 5, 3, 7, 1'b1, "hold_a");
      drive_fields(100, 200, 4, 2, 9);
      chk("hold_ready_at_done", 32'(bus.cmd_ready), 32'd1);
      @(posedge Clk);
      #1;
      chk("hold_b_accepted", 32'(bus.cmd_ready), 32'd0);
      chk("hold_done_single", 32'(done), 32'd0);
      bus.cmd_valid = 1'b0;
      collect(100, 200, 4, 2, 9, 1'b0, "hold_b");
      @(posedge Clk);
      #1;

      // Reset while the third pixel of a 4x4 fill is on the bus.
      start_cmd(5, 5, 4, 4, 3, 1'b0);
      wcnt = 0;
      for (int k = 1; k <= 4; k++) begin
         @(posedge Clk);
         #1;
         if (bus.WE) wcnt++;
      end
      chk("rstmid_writes_before", 32'(wcnt), 32'd3);
      Reset_h = 1'b1;
      @(posedge Clk);
      #1;
      chk("rstmid_we", 32'(bus.WE), 32'd0);
      chk("rstmid_ready", 32'(bus.cmd_ready), 32'd1);
      chk("rstmid_done", 32'(done), 32'd0);
      Reset_h = 1'b0;
      @(posedge Clk);
      #1;
      chk("rstmid_no_done", 32'(done), 32'd0);
      run_cmd(1, 2, 2, 2, 6, "after_rst");

      for (int i = 0; i < 10; i++)
         run_cmd($urandom_range(0, 700), $urandom_range(0, 500),
                 $urandom_range(0, 24), $urandom_range(0, 12),
                 $urandom_range(0, 15), $sformatf("rand%0d", i));

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/frame_rect_filler.md
Name: frame_rect_filler

Overview:
- Upstream drawing engine for the 640x480, 4-bit-per-pixel frame buffer.
- Accepts one rectangle-fill command at a time over a valid/ready handshake.
- Clips the rectangle to the screen and emits one frame-buffer write per clock: write enable, linear pixel index and palette colour.
- A full-screen clear is issued as a rectangle command with x=0, y=0, w=640, h=480.

Parameters:
- H_RES, 640, visible pixels per line; also the row stride of the linear pixel index.
- V_RES, 480, visible lines.
- PIX_W, 4, palette-index width per pixel.

Ports:
- Clk  in  1  system clock.
- Reset_h  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  block can accept a command.
- cmd_x  in  10  left column.
- cmd_y  in  9  top row.
- cmd_w  in  10  width in pixels.
- cmd_h  in  9  height in lines.
- cmd_color  in  PIX_W  fill palette index.
- WE  out  1  frame-buffer write enable.
- drawPtFrame  out  20  linear write index = row*H_RES + col.
- drawData  out  PIX_W  write data.
- busy  out  1  command in progress.
- done  out  1  one-cycle pulse when a command completes.

Behaviour:
- All logic is on posedge Clk.
- Reset_h is synchronous and active-high. On reset: state IDLE, WE=0, drawPtFrame=0, drawData=0, busy=0, done=0.
- cmd_ready = (state==IDLE). It is combinational, so it reads 1 while in reset and IDLE.
- States: IDLE, SETUP, FILL, DONE.
- IDLE:
  - Accept a command when cmd_valid && cmd_ready.
  - Latch x, y, w, h and color.
  - Go to SETUP.
- SETUP (1 cycle):
  - Compute x_end = min(x+w, H_RES) and y_end = min(y+h, V_RES), using 11-bit and 10-bit sums so there is no overflow.
  - row_base = y*H_RES. Compute it with shift-add (y<<9 + y<<7); no generic multiplier.
  - Empty command (w==0, h==0, x>=H_RES or y>=V_RES) -> DONE with no writes.
  - Otherwise -> FILL with col=x and row=y.
- FILL (one write per cycle):
  - Registered outputs: WE=1, drawPtFrame=row_base+col, drawData=color.
  - col increments each cycle.
  - When col==x_end-1: col<=x, row<=row+1, row_base<=row_base+H_RES.
  - When row==y_end-1 and col==x_end-1: -> DONE.
- DONE (1 cycle):
  - WE=0, done=1.
  - -> IDLE.
- busy=1 in SETUP, FILL and DONE.
- Timing:
  - Command accepted at edge T.
  - First WE=1 is visible after edge T+2.
  - WE is high for exactly clipped_w*clipped_h consecutive cycles, with no gaps.
  - done pulses the cycle after the last WE.
  - cmd_ready returns to 1 the cycle after done.
- Writes are emitted in row-major order. drawPtFrame never exceeds 307199.
- cmd_* inputs are ignored while busy. Command fields are latched only at acceptance, so input changes mid-fill have no effect.
- Reset mid-FILL: the next edge forces WE=0 and state IDLE. Pixels already written stay in the buffer. No done pulse.
- cmd_valid held high during DONE is accepted in the following IDLE cycle. Back-to-back throughput is limited to one command per (3 + pixels) cycles.

Decomposition:
- Shared package frame_pkg:
  - H_RES, V_RES, FB_DEPTH=307200, FB_ADDR_W=20, PIX_W.
  - Enum fill_state_t {IDLE, SETUP, FILL, DONE}.
  - Also used by the frame buffer and the VGA read side.
- One combinational sub-module, frame_rect_clip: takes x/y/w/h and produces x_end, y_end and an empty flag. Keeping it separate makes the clipping arithmetic testable on its own.

Test Plan:
- Reset, then cmd x=2, y=1, w=3, h=2, color=4'hA -> WE high for exactly 6 cycles; drawPtFrame = 642, 643, 644, 1282, 1283, 1284; drawData=A; done pulses once; first write 2 cycles after acceptance.
- Clear: x=0, y=0, w=640, h=480, color=0 -> 307200 consecutive writes, indices 0..307199 in order; final index 307199; no write beyond.
- Clip: x=638, y=479, w=10, h=10, color=5 -> exactly 2 writes, at 307198 and 307199; then done.
- Empty: w=0 (and separately x=700) -> no WE; done pulses 2 cycles after acceptance.
- Handshake: cmd_valid held high with changing fields during a fill -> only the first command runs; the second is accepted in the first IDLE cycle after done.
- Reset asserted on the 3rd write of a 4x4 fill -> WE=0 and cmd_ready=1 after that edge; no done; a new command is then accepted normally.
